// File: rtl/seven_seg_pkg.sv
// Shared types and the hex font for the seven-segment scanner.
// Segment vectors are gfedcba with bit 0 = a.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF_N = 7'h7F;

    typedef enum logic {
        BLANK,
        DISPLAY
    } scan_state_t;

    // Returns the active-high segment pattern for one hex digit.
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        unique case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_sync_edge_detect.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// rise_pulse is one clock wide for each rising edge seen at the end of the chain.
module sync_edge_detect #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [STAGES-1:0] sync_chain;
    logic              sync_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            sync_last  <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[STAGES-2:0], async_in};
            sync_last  <= sync_chain[STAGES-1];
        end
    end

    assign rise_pulse = sync_chain[STAGES-1] & ~sync_last;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with per-digit blanking gap,
// per-frame value latching and optional leading-zero suppression.
module seven_seg_scanner #(
    parameter int unsigned DIGITS             = 4,
    parameter int unsigned LEADING_ZERO_BLANK = 1,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       scan_clock,
    input  logic [4*DIGITS-1:0]        value,
    input  logic                       enable,
    output logic [DIGITS-1:0]          anodes_n,
    output logic [6:0]                 segments_n,
    output logic [$clog2(DIGITS)-1:0]  digit,
    output logic                       frame_start
);

    import seven_seg_pkg::*;

    localparam int unsigned DW = $clog2(DIGITS);

    scan_state_t          state;
    logic [4*DIGITS-1:0]  frame;
    logic                 step;
    logic [DIGITS-1:0]    suppress;
    logic                 zero_above;
    logic [3:0]           nibble;
    logic                 lit;
    logic [DIGITS-1:0]    one_hot;

    sync_edge_detect #(
        .STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .clock     (clock),
        .reset     (reset),
        .async_in  (scan_clock),
        .rise_pulse(step)
    );

    // Digit d>0 goes dark when it and every more significant nibble are zero.
    always_comb begin
        suppress   = '0;
        zero_above = 1'b1;
        for (int d = DIGITS - 1; d > 0; d--) begin
            zero_above  = zero_above & (frame[4*d +: 4] == 4'h0);
            suppress[d] = (LEADING_ZERO_BLANK != 0) && zero_above;
        end
    end

    always_comb begin
        nibble  = frame[4*int'(digit) +: 4];
        lit     = enable & ~suppress[digit];
        one_hot = {{(DIGITS-1){1'b0}}, 1'b1} << digit;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= BLANK;
            digit       <= '0;
            frame       <= '0;
            anodes_n    <= '1;
            segments_n  <= SEG_OFF_N;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (step) begin
                state      <= BLANK;
                anodes_n   <= '1;
                segments_n <= SEG_OFF_N;
                if (digit == DW'(DIGITS - 1)) begin
                    digit       <= '0;
                    frame       <= value;
                    frame_start <= 1'b1;
                end else begin
                    digit <= digit + DW'(1);
                end
            end else begin
                // BLANK always leaves after one cycle; DISPLAY holds until the next step.
                if (state == BLANK) begin
                    state <= DISPLAY;
                end
                if (lit) begin
                    anodes_n   <= ~one_hot;
                    segments_n <= ~hex_to_seg(nibble);
                end else begin
                    anodes_n   <= '1;
                    segments_n <= SEG_OFF_N;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a behavioural model; two instances
// cover leading-zero blanking on and off with shared stimulus.
module tb_seven_seg_scanner;

    localparam int DIGITS = 4;
    localparam int S      = 2;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        scan_clock = 1'b0;
    logic        enable     = 1'b0;
    logic [15:0] value      = 16'h0000;

    logic [3:0] a_an, b_an;
    logic [6:0] a_seg, b_seg;
    logic [1:0] a_digit, b_digit;
    logic       a_fs, b_fs;

    int checks = 0;
    int errors = 0;

    seven_seg_scanner #(
        .DIGITS(DIGITS), .LEADING_ZERO_BLANK(1), .SYNC_STAGES(S)
    ) u_dut_lzb (
        .clock(clock), .reset(reset), .scan_clock(scan_clock), .value(value),
        .enable(enable), .anodes_n(a_an), .segments_n(a_seg), .digit(a_digit),
        .frame_start(a_fs)
    );

    seven_seg_scanner #(
        .DIGITS(DIGITS), .LEADING_ZERO_BLANK(0), .SYNC_STAGES(S)
    ) u_dut_nolzb (
        .clock(clock), .reset(reset), .scan_clock(scan_clock), .value(value),
        .enable(enable), .anodes_n(b_an), .segments_n(b_seg), .digit(b_digit),
        .frame_start(b_fs)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [6:0]  font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          m_digit;
    logic [15:0] m_frame;
    bit          m_fs;
    logic [3:0]  e_an [2];
    logic [6:0]  e_seg [2];
    bit          hist [$];   // last S+1 scan_clock samples, oldest first

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    function automatic void model_reset();
        m_digit = 0;
        m_frame = 16'h0000;
        m_fs    = 1'b0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(1'b0);
        for (int i = 0; i < 2; i++) begin
            e_an[i]  = 4'hF;
            e_seg[i] = 7'h7F;
        end
    endfunction

    function automatic void model_edge();
        bit step;
        int nib;
        bit lit;
        if (reset) begin
            model_reset();
            return;
        end
        // A sample taken S edges ago that rose from the one before it is a step now.
        step = hist[1] && !hist[0];
        hist.push_back(scan_clock);
        void'(hist.pop_front());
        m_fs = 1'b0;
        if (step) begin
            if (m_digit == DIGITS - 1) begin
                m_digit = 0;
                m_frame = value;
                m_fs    = 1'b1;
            end else begin
                m_digit++;
            end
            for (int i = 0; i < 2; i++) begin
                e_an[i]  = 4'hF;
                e_seg[i] = 7'h7F;
            end
        end else begin
            nib = int'((m_frame >> (4 * m_digit)) & 16'hF);
            for (int i = 0; i < 2; i++) begin
                lit = enable && !(i == 0 && m_digit > 0 && (m_frame >> (4 * m_digit)) == 0);
                if (lit) begin
                    e_an[i]  = ~(4'b0001 << m_digit);
                    e_seg[i] = ~font[nib];
                end else begin
                    e_an[i]  = 4'hF;
                    e_seg[i] = 7'h7F;
                end
            end
        end
    endfunction

    task automatic compare_all();
        check("lzb_anodes",      32'(a_an),    32'(e_an[0]));
        check("lzb_segments",    32'(a_seg),   32'(e_seg[0]));
        check("lzb_digit",       32'(a_digit), 32'(m_digit));
        check("lzb_frame_start", 32'(a_fs),    32'(m_fs));
        check("nolzb_anodes",    32'(b_an),    32'(e_an[1]));
        check("nolzb_segments",  32'(b_seg),   32'(e_seg[1]));
        check("nolzb_digit",     32'(b_digit), 32'(m_digit));
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_scan(input int cycles, input int period);
        for (int c = 0; c < cycles; c++) begin
            scan_clock = (c % period) < (period / 2);
            tick();
        end
    endtask

    initial begin
        model_reset();

        // Reset held while the strobe toggles, then release with strobe low
        for (int i = 0; i < 6; i++) begin
            scan_clock = ~scan_clock;
            tick();
        end
        scan_clock = 1'b0;
        reset      = 1'b0;
        repeat (4) tick();

        // Steady scanning, with a value change partway through a frame
        value  = 16'h12AF;
        enable = 1'b1;
        for (int c = 0; c < 16 * 4 * 3; c++) begin
            scan_clock = (c % 16) < 8;
            if (c == 16 * 4 * 2 + 20) value = 16'h3456;
            tick();
        end
        run_scan(16 * 4 * 2, 16);

        // Leading-zero cases
        value = 16'h0040;
        run_scan(16 * 4 * 2, 16);
        value = 16'h0000;
        run_scan(16 * 4 * 2, 16);

        // Back-to-back steps
        value = 16'hBEEF;
        run_scan(64, 2);

        // Display disabled for a few steps, scanning continues
        value  = 16'h9C07;
        run_scan(16 * 4, 16);
        enable = 1'b0;
        run_scan(16 * 3, 16);
        enable = 1'b1;
        run_scan(20, 16);

        // Asynchronous reset between clock edges
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        run_scan(4, 2);
        scan_clock = 1'b0;
        reset      = 1'b0;
        repeat (3) tick();

        // Randomized strobe, value and enable
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) scan_clock = ~scan_clock;
            if ($urandom_range(0, 63) == 0) value = 16'($urandom);
            if ($urandom_range(0, 15) == 0) value = 16'($urandom_range(0, 255));
            enable = ($urandom_range(0, 9) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
